// File: rtl/pipeline_perf_monitor.sv
// Run-control and observability unit for the pipelined processor: event counters,
// halt/timeout detection and a ready/valid trace FIFO of register writebacks.
module pipeline_perf_monitor #(
    parameter int          XLEN       = 32,
    parameter int          CNT_W      = 32,
    parameter int          DEPTH      = 16,
    parameter int          MAX_CYCLES = 500,
    parameter int          DRAIN_CYC  = 4,
    parameter logic [31:0] HALT_INSTR = 32'h0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      instr_if,
    input  logic             pc_write,
    input  logic             flush,
    input  logic [1:0]       forward_a,
    input  logic [1:0]       forward_b,
    input  logic             wb_en,
    input  logic [4:0]       wb_rd,
    input  logic [XLEN-1:0]  wb_data,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] fetch_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] fwd_cnt,
    output logic             trace_valid,
    input  logic             trace_ready,
    output logic [4:0]       trace_rd,
    output logic [XLEN-1:0]  trace_data,
    output logic             overflow,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = $clog2(DRAIN_CYC) + 1;

    typedef enum logic [2:0] {IDLE, RUN, DRAIN, DONE, TIMEOUT} state_t;

    state_t          state, state_next;
    logic [DW-1:0]   drain_cnt;
    logic            start_ok, halt, limit;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic [4:0]      mem_rd   [DEPTH];
    logic [XLEN-1:0] mem_data [DEPTH];
    logic            push_req, push_ok, pop, full, drop;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign start_ok = start && (state == IDLE || state == DONE || state == TIMEOUT);
    assign halt     = (state == RUN) && (instr_if == HALT_INSTR) && pc_write;
    assign limit    = (state == RUN) && (cycle_cnt == CNT_W'(MAX_CYCLES - 1));

    assign busy    = (state == RUN) || (state == DRAIN);
    assign done    = (state == DONE);
    assign timeout = (state == TIMEOUT);

    // Halt takes priority over the cycle limit when both fire on the same edge.
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE, TIMEOUT: if (start) state_next = RUN;
            RUN: begin
                if (halt)       state_next = DRAIN;
                else if (limit) state_next = TIMEOUT;
            end
            DRAIN:   if (drain_cnt == '0) state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!reset)                                drain_cnt <= '0;
        else if (halt)                             drain_cnt <= DW'(DRAIN_CYC - 1);
        else if (state == DRAIN && drain_cnt != '0) drain_cnt <= drain_cnt - DW'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset || start_ok) begin
            cycle_cnt <= '0;
            fetch_cnt <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
            fwd_cnt   <= '0;
        end else if (state == RUN) begin
            cycle_cnt <= sat_inc(cycle_cnt);
            if (pc_write) fetch_cnt <= sat_inc(fetch_cnt);
            else          stall_cnt <= sat_inc(stall_cnt);
            if (flush)    flush_cnt <= sat_inc(flush_cnt);
            if (forward_a != 2'b00 || forward_b != 2'b00) fwd_cnt <= sat_inc(fwd_cnt);
        end
    end

    // A push into a full FIFO survives if the head leaves on the same edge.
    assign push_req    = wb_en && (wb_rd != 5'd0) && ((state == RUN) || (state == DRAIN));
    assign trace_valid = (count != '0);
    assign pop         = trace_valid && trace_ready;
    assign full        = (count == CW'(DEPTH));
    assign push_ok     = push_req && (!full || pop);
    assign drop        = push_req && full && !pop;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_rd[wr_ptr]   <= wb_rd;
            mem_data[wr_ptr] <= wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || start_ok) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
                drop_cnt <= sat_inc(drop_cnt);
            end
        end
    end

    assign trace_rd   = mem_rd[rd_ptr];
    assign trace_data = mem_data[rd_ptr];

endmodule
